payload_tx_scheduler: RTL and testbench



---
 rtl/payload_tx_scheduler_pkg.sv | 10 +
 rtl/payload_tx_scheduler_credit_counter.sv | 28 ++
 rtl/payload_tx_scheduler.sv | 90 +++++++++
 tb/tb_payload_tx_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/payload_tx_scheduler_pkg.sv
// payload_tx_scheduler_pkg: header field offsets, beat/credit geometry and FSM states
package payload_tx_scheduler_pkg;
    localparam int PIPE_DATA_WIDTH = 256;
    localparam int LEN_LSB = 0;
    localparam int LEN_MSB = 9;
    localparam int HAS_DATA_BIT = 30;
    localparam int DW_PER_BEAT = PIPE_DATA_WIDTH / 32;
    localparam int CREDIT_UNIT_DW = 4;
    typedef enum logic {IDLE, DATA} sched_state_t;
endpackage

// File: rtl/payload_tx_scheduler_credit_counter.sv
// payload_tx_scheduler_credit_counter: posted-data credit pool with init priority and saturating returns
module payload_tx_scheduler_credit_counter #(
    parameter int CREDIT_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init_valid,
    input  logic [CREDIT_WIDTH-1:0] init_value,
    input  logic                    return_valid,
    input  logic [7:0]              return_value,
    input  logic                    deduct_valid,
    input  logic [CREDIT_WIDTH-1:0] deduct_value,
    output logic [CREDIT_WIDTH-1:0] avail
);
    logic [CREDIT_WIDTH-1:0] base;
    logic [CREDIT_WIDTH:0]   sum;

    assign base = deduct_valid ? avail - deduct_value : avail;
    assign sum  = {1'b0, base} + (return_valid ? {{(CREDIT_WIDTH-7){1'b0}}, return_value} : '0);

    always_ff @(posedge clk or posedge rst)
        if (rst)
            avail <= '0;
        else if (init_valid)
            avail <= init_value;
        else
            avail <= sum[CREDIT_WIDTH] ? '1 : sum[CREDIT_WIDTH-1:0];
endmodule

// File: rtl/payload_tx_scheduler.sv
// payload_tx_scheduler: pairs header and payload FIFOs into credit-gated header-then-payload TLPs
module payload_tx_scheduler
    import payload_tx_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH   = PIPE_DATA_WIDTH,
    parameter int HDR_WIDTH    = 128,
    parameter int CREDIT_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hdr_fifo_empty,
    input  logic [HDR_WIDTH-1:0]    hdr_fifo_rdata,
    output logic                    hdr_fifo_rden,
    input  logic                    payload_fifo_empty,
    input  logic [DATA_WIDTH-1:0]   payload_fifo_rdata,
    input  logic                    payload_fifo_last,
    output logic                    payload_fifo_rden,
    output logic                    tlp_valid,
    input  logic                    tlp_ready,
    output logic [DATA_WIDTH-1:0]   tlp_data,
    output logic                    tlp_sop,
    output logic                    tlp_eop,
    input  logic                    credit_init_valid,
    input  logic [CREDIT_WIDTH-1:0] credit_init_value,
    input  logic                    credit_return_valid,
    input  logic [7:0]              credit_return_value,
    output logic [CREDIT_WIDTH-1:0] credit_avail,
    output logic                    framing_err
);
    sched_state_t            state;
    logic [7:0]              beat_cnt;
    logic [10:0]             len_full;
    logic [7:0]              beats;
    logic [CREDIT_WIDTH-1:0] need;
    logic                    has_payload, can_load, launch, pop, last_beat;

    // a zero length field encodes the maximum 1024-DW transfer
    assign len_full    = hdr_fifo_rdata[LEN_MSB:LEN_LSB] == '0 ? 11'd1024 : {1'b0, hdr_fifo_rdata[LEN_MSB:LEN_LSB]};
    assign has_payload = hdr_fifo_rdata[HAS_DATA_BIT];
    assign beats       = 8'((len_full + 11'(DW_PER_BEAT - 1)) / 11'(DW_PER_BEAT));
    assign need        = CREDIT_WIDTH'((len_full + 11'(CREDIT_UNIT_DW - 1)) / 11'(CREDIT_UNIT_DW));
    assign last_beat   = beat_cnt == 8'd1;
    assign can_load    = !tlp_valid || tlp_ready;
    assign launch      = state == IDLE && can_load && !hdr_fifo_empty && (!has_payload || credit_avail >= need);
    assign pop         = state == DATA && can_load && !payload_fifo_empty;
    assign hdr_fifo_rden     = launch && !rst;
    assign payload_fifo_rden = pop && !rst;

    payload_tx_scheduler_credit_counter #(.CREDIT_WIDTH(CREDIT_WIDTH)) u_credit (
        .clk          (clk),
        .rst          (rst),
        .init_valid   (credit_init_valid),
        .init_value   (credit_init_value),
        .return_valid (credit_return_valid),
        .return_value (credit_return_value),
        .deduct_valid (launch && has_payload),
        .deduct_value (need),
        .avail        (credit_avail)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            tlp_valid   <= 1'b0;
            tlp_data    <= '0;
            tlp_sop     <= 1'b0;
            tlp_eop     <= 1'b0;
            framing_err <= 1'b0;
        end else if (launch) begin
            tlp_valid <= 1'b1;
            tlp_data  <= {{(DATA_WIDTH-HDR_WIDTH){1'b0}}, hdr_fifo_rdata};
            tlp_sop   <= 1'b1;
            tlp_eop   <= !has_payload;
            if (has_payload) begin
                beat_cnt <= beats;
                state    <= DATA;
            end
        end else if (pop) begin
            tlp_valid <= 1'b1;
            tlp_data  <= payload_fifo_rdata;
            tlp_sop   <= 1'b0;
            tlp_eop   <= last_beat;
            beat_cnt  <= beat_cnt - 8'd1;
            state     <= last_beat ? IDLE : DATA;
            if (payload_fifo_last != last_beat)
                framing_err <= 1'b1;
        end else if (tlp_ready)
            tlp_valid <= 1'b0;
endmodule

// File: tb/tb_payload_tx_scheduler.sv
// tb_payload_tx_scheduler: table-driven TLP vectors plus hand sequences for stall, credits, framing and reset
module tb_payload_tx_scheduler;
    localparam int DW = 256;
    localparam int HW = 128;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hdr_fifo_empty, hdr_fifo_rden;
    logic [HW-1:0] hdr_fifo_rdata;
    logic          payload_fifo_empty, payload_fifo_last, payload_fifo_rden;
    logic [DW-1:0] payload_fifo_rdata;
    logic          tlp_valid, tlp_sop, tlp_eop, framing_err;
    logic          tlp_ready = 1'b1;
    logic [DW-1:0] tlp_data;
    logic          credit_init_valid = 1'b0;
    logic [CW-1:0] credit_init_value = '0;
    logic          credit_return_valid = 1'b0;
    logic [7:0]    credit_return_value = '0;
    logic [CW-1:0] credit_avail;

    always #5 clk = ~clk;

    payload_tx_scheduler dut (
        .clk(clk), .rst(rst),
        .hdr_fifo_empty(hdr_fifo_empty), .hdr_fifo_rdata(hdr_fifo_rdata), .hdr_fifo_rden(hdr_fifo_rden),
        .payload_fifo_empty(payload_fifo_empty), .payload_fifo_rdata(payload_fifo_rdata),
        .payload_fifo_last(payload_fifo_last), .payload_fifo_rden(payload_fifo_rden),
        .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tlp_data(tlp_data), .tlp_sop(tlp_sop), .tlp_eop(tlp_eop),
        .credit_init_valid(credit_init_valid), .credit_init_value(credit_init_value),
        .credit_return_valid(credit_return_valid), .credit_return_value(credit_return_value),
        .credit_avail(credit_avail), .framing_err(framing_err)
    );

    // show-ahead FIFO models
    logic [HW-1:0] hdr_mem [0:1023];
    logic [DW-1:0] pay_mem [0:1023];
    logic          pay_last_mem [0:1023];
    int hdr_wr = 0, hdr_rd = 0, pay_wr = 0, pay_rd = 0, pay_seq = 0;

    assign hdr_fifo_empty     = hdr_rd == hdr_wr;
    assign hdr_fifo_rdata     = hdr_mem[hdr_rd[9:0]];
    assign payload_fifo_empty = pay_rd == pay_wr;
    assign payload_fifo_rdata = pay_mem[pay_rd[9:0]];
    assign payload_fifo_last  = pay_last_mem[pay_rd[9:0]];

    always @(posedge clk) begin
        if (hdr_fifo_rden) hdr_rd <= hdr_rd + 1;
        if (payload_fifo_rden) pay_rd <= pay_rd + 1;
    end

    // inputs only change at posedge+2, so the negedge view is what the next edge accepts
    logic [DW-1:0] mon_data [0:1023];
    logic          mon_sop [0:1023];
    logic          mon_eop [0:1023];
    int mon_n = 0;

    always @(negedge clk)
        if (tlp_valid && tlp_ready && !rst) begin
            mon_data[mon_n[9:0]] <= tlp_data;
            mon_sop[mon_n[9:0]]  <= tlp_sop;
            mon_eop[mon_n[9:0]]  <= tlp_eop;
            mon_n <= mon_n + 1;
        end

    int checks = 0, errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(int s);
        return {8{32'(s) ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [HW-1:0] mk_hdr(int len, bit has, int tag);
        logic [HW-1:0] h;
        h = '0;
        h[9:0] = 10'(len);
        h[30] = has;
        h[127:96] = 32'(tag);
        return h;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic load_credit(int v);
        credit_init_valid = 1'b1;
        credit_init_value = CW'(v);
        step();
        credit_init_valid = 1'b0;
    endtask

    task automatic push_hdr(logic [HW-1:0] h);
        hdr_mem[hdr_wr[9:0]] = h;
        hdr_wr++;
    endtask

    task automatic push_pay(int n, int last_pos, output int first);
        first = pay_seq;
        for (int k = 0; k < n; k++) begin
            pay_mem[pay_wr[9:0]] = pat(pay_seq);
            pay_last_mem[pay_wr[9:0]] = (k == last_pos);
            pay_wr++;
            pay_seq++;
        end
    endtask

    task automatic wait_eop(string name, int start);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            done = mon_n > start && mon_eop[mon_n-1];
        end
        chk({name, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic check_tlp(string name, int start, logic [HW-1:0] h, int nd, int first);
        int bad;
        logic [DW-1:0] e;
        bad = 0;
        chk({name, "_beats"}, 64'(mon_n - start), 64'(nd + 1));
        for (int i = 0; i <= nd; i++) begin
            e = (i == 0) ? {{(DW-HW){1'b0}}, h} : pat(first + i - 1);
            if (mon_data[start+i] !== e || mon_sop[start+i] !== (i == 0) || mon_eop[start+i] !== (i == nd))
                bad++;
        end
        chk({name, "_content"}, 64'(bad), 64'd0);
    endtask

    typedef struct {
        int len;
        bit has;
        int init;
        int nd;
        int avail;
    } vec_t;

    vec_t vt [8];

    initial begin
        int start, first, f2, pr0;
        logic [HW-1:0] h, h2;
        vt[0] = '{16,   1'b1, 16,  2,   12};
        vt[1] = '{1,    1'b1, 10,  1,   9};
        vt[2] = '{8,    1'b1, 10,  1,   8};
        vt[3] = '{9,    1'b1, 10,  2,   7};
        vt[4] = '{40,   1'b1, 10,  5,   0};
        vt[5] = '{5,    1'b0, 3,   0,   3};
        vt[6] = '{0,    1'b1, 256, 128, 0};
        vt[7] = '{1023, 1'b1, 300, 128, 44};

        @(posedge clk);
        #1;
        chk("rst_valid", 64'(tlp_valid), 64'd0);
        chk("rst_sopeop", 64'({tlp_sop, tlp_eop}), 64'd0);
        chk("rst_data_zero", 64'(tlp_data == '0), 64'd1);
        chk("rst_avail", 64'(credit_avail), 64'd0);
        chk("rst_ferr", 64'(framing_err), 64'd0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            load_credit(vt[v].init);
            h = mk_hdr(vt[v].len, vt[v].has, v);
            push_pay(vt[v].nd, vt[v].nd - 1, first);
            start = mon_n;
            push_hdr(h);
            wait_eop($sformatf("vec%0d", v), start);
            check_tlp($sformatf("vec%0d", v), start, h, vt[v].nd, first);
            chk($sformatf("vec%0d_avail", v), 64'(credit_avail), 64'(vt[v].avail));
            chk($sformatf("vec%0d_ferr", v), 64'(framing_err), 64'd0);
            chk($sformatf("vec%0d_drained", v), 64'(pay_rd == pay_wr && hdr_rd == hdr_wr), 64'd1);
        end

        // insufficient credits hold the header until a return arrives
        do_reset();
        load_credit(2);
        h = mk_hdr(16, 1'b1, 100);
        push_pay(2, 1, first);
        start = mon_n;
        push_hdr(h);
        step();
        step();
        step();
        chk("cred_wait_valid", 64'(tlp_valid), 64'd0);
        chk("cred_wait_hdr", 64'(hdr_fifo_empty), 64'd0);
        chk("cred_wait_avail", 64'(credit_avail), 64'd2);
        credit_return_valid = 1'b1;
        credit_return_value = 8'd2;
        step();
        credit_return_valid = 1'b0;
        chk("cred_ret_avail", 64'(credit_avail), 64'd4);
        chk("cred_ret_valid", 64'(tlp_valid), 64'd0);
        step();
        chk("cred_launch", 64'({tlp_valid, tlp_sop}), 64'b11);
        chk("cred_launch_avail", 64'(credit_avail), 64'd0);
        wait_eop("cred", start);
        check_tlp("cred", start, h, 2, first);

        // backpressure on the header and on a data beat
        do_reset();
        load_credit(16);
        tlp_ready = 1'b0;
        h = mk_hdr(24, 1'b1, 200);
        push_pay(3, 2, first);
        pr0 = pay_rd;
        start = mon_n;
        push_hdr(h);
        step();
        step();
        step();
        step();
        chk("stall_hdr_data", 64'(tlp_data == {{(DW-HW){1'b0}}, h}), 64'd1);
        chk("stall_hdr_nopop", 64'(pay_rd - pr0), 64'd0);
        tlp_ready = 1'b1;
        step();
        tlp_ready = 1'b0;
        step();
        step();
        step();
        chk("stall_beat_data", 64'(tlp_data == pat(first)), 64'd1);
        chk("stall_beat_valid", 64'(tlp_valid), 64'd1);
        chk("stall_beat_nopop", 64'(pay_rd - pr0), 64'd1);
        tlp_ready = 1'b1;
        wait_eop("stall", start);
        check_tlp("stall", start, h, 3, first);

        // early last marker flags framing; transfer still completes by count
        do_reset();
        load_credit(16);
        h = mk_hdr(16, 1'b1, 300);
        push_pay(2, 0, first);
        start = mon_n;
        push_hdr(h);
        wait_eop("frame", start);
        check_tlp("frame", start, h, 2, first);
        chk("frame_err_set", 64'(framing_err), 64'd1);
        h = mk_hdr(8, 1'b1, 301);
        push_pay(1, 0, first);
        start = mon_n;
        push_hdr(h);
        wait_eop("frame2", start);
        check_tlp("frame2", start, h, 1, first);
        chk("frame_err_sticky", 64'(framing_err), 64'd1);
        do_reset();
        chk("frame_err_rst", 64'(framing_err), 64'd0);

        // init outranks a same-cycle return and launch deduction
        load_credit(16);
        h = mk_hdr(16, 1'b1, 400);
        push_pay(2, 1, first);
        start = mon_n;
        push_hdr(h);
        credit_init_valid = 1'b1;
        credit_init_value = 12'd5;
        credit_return_valid = 1'b1;
        credit_return_value = 8'd3;
        step();
        credit_init_valid = 1'b0;
        credit_return_valid = 1'b0;
        chk("init_prio_launch", 64'({tlp_valid, tlp_sop}), 64'b11);
        chk("init_prio_avail", 64'(credit_avail), 64'd5);
        wait_eop("init_prio", start);
        check_tlp("init_prio", start, h, 2, first);
        chk("init_prio_after", 64'(credit_avail), 64'd5);
        credit_return_valid = 1'b1;
        credit_return_value = 8'd3;
        step();
        credit_return_valid = 1'b0;
        chk("ret_add", 64'(credit_avail), 64'd8);
        load_credit(4094);
        credit_return_valid = 1'b1;
        credit_return_value = 8'd5;
        step();
        credit_return_valid = 1'b0;
        chk("ret_saturate", 64'(credit_avail), 64'd4095);

        // payload underrun bubble, then asynchronous reset mid-TLP
        do_reset();
        load_credit(16);
        h = mk_hdr(24, 1'b1, 500);
        push_pay(1, 2, first);
        push_hdr(h);
        step();
        step();
        step();
        chk("bubble_valid", 64'(tlp_valid), 64'd0);
        chk("bubble_consumed", 64'(pay_rd == pay_wr), 64'd1);
        push_pay(2, 1, f2);
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(tlp_valid), 64'd0);
        chk("arst_sopeop", 64'({tlp_sop, tlp_eop}), 64'd0);
        chk("arst_data_zero", 64'(tlp_data == '0), 64'd1);
        chk("arst_avail", 64'(credit_avail), 64'd0);
        chk("arst_rden", 64'({hdr_fifo_rden, payload_fifo_rden}), 64'd0);
        step();
        rst = 1'b0;
        pr0 = pay_rd;
        step();
        step();
        step();
        chk("idle_no_pop", 64'(pay_rd - pr0), 64'd0);
        chk("idle_valid", 64'(tlp_valid), 64'd0);

        // header-only TLPs run back-to-back without credits
        h = mk_hdr(4, 1'b0, 600);
        h2 = mk_hdr(7, 1'b0, 601);
        start = mon_n;
        push_hdr(h);
        push_hdr(h2);
        step();
        step();
        step();
        step();
        chk("b2b_count", 64'(mon_n - start), 64'd2);
        chk("b2b_first", 64'(mon_data[start] == {{(DW-HW){1'b0}}, h} && mon_sop[start] && mon_eop[start]), 64'd1);
        chk("b2b_second", 64'(mon_data[start+1] == {{(DW-HW){1'b0}}, h2} && mon_sop[start+1] && mon_eop[start+1]), 64'd1);

        // leftover payload survives reset and pairs with the next header
        load_credit(4);
        h = mk_hdr(16, 1'b1, 700);
        start = mon_n;
        push_hdr(h);
        wait_eop("leftover", start);
        check_tlp("leftover", start, h, 2, f2);
        chk("leftover_avail", 64'(credit_avail), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
